// File: rtl/bsg_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : bsg_reset_sequencer
//  Description : Staged reset-release controller. Holds every downstream
//                stage in reset after chip reset, then releases the stages in
//                order. Each release is followed by a fixed settle wait and a
//                bounded wait for that stage's ready acknowledge.
//  Revision    : 1.0 - initial release
// ============================================================================
module bsg_reset_sequencer #(
  parameter int num_stages_p     = 4,
  parameter int hold_cycles_p    = 8,
  parameter int wait_cycles_p    = 16,
  parameter int timeout_cycles_p = 255,
  localparam int c_idx_w = (num_stages_p > 1) ? $clog2(num_stages_p) : 1
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    restart_i,
  input  logic [num_stages_p-1:0] stage_ready_i,
  output logic [num_stages_p-1:0] stage_reset_o,
  output logic                    done_o,
  output logic                    error_o,
  output logic [c_idx_w-1:0]      err_stage_o
);

  // One shared counter must cover the longest of the three intervals.
  localparam int c_cnt_max_hw = (hold_cycles_p > wait_cycles_p) ? hold_cycles_p : wait_cycles_p;
  localparam int c_cnt_max    = (c_cnt_max_hw > timeout_cycles_p) ? c_cnt_max_hw : timeout_cycles_p;
  localparam int c_cnt_w      = $clog2(c_cnt_max + 1);

  localparam logic [c_cnt_w-1:0] c_cnt_sat      = c_cnt_w'(c_cnt_max);
  localparam logic [c_cnt_w-1:0] c_hold_last    = c_cnt_w'(hold_cycles_p - 1);
  localparam logic [c_cnt_w-1:0] c_wait_last    = c_cnt_w'(wait_cycles_p - 1);
  localparam logic [c_cnt_w-1:0] c_timeout_last = c_cnt_w'(timeout_cycles_p - 1);
  localparam logic [c_idx_w-1:0] c_idx_last     = c_idx_w'(num_stages_p - 1);

  typedef enum logic [2:0] {
    s_hold  = 3'd0,
    s_wait  = 3'd1,
    s_check = 3'd2,
    s_done  = 3'd3,
    s_error = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [c_cnt_w-1:0]      cnt_q, cnt_d;
  logic [c_idx_w-1:0]      idx_q, idx_d;
  logic [num_stages_p-1:0] stage_reset_q, stage_reset_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;
  logic [c_idx_w-1:0]      err_stage_q, err_stage_d;

  logic [c_cnt_w-1:0]      cnt_inc;
  logic [c_idx_w-1:0]      idx_nxt;
  logic                    ready_sel;
  logic [num_stages_p-1:0] release_mask;

  // Selected ready bit, saturating counter step and one-hot mask of the next stage.
  always_comb begin
    cnt_inc      = (cnt_q == c_cnt_sat) ? cnt_q : cnt_q + c_cnt_w'(1);
    idx_nxt      = idx_q + c_idx_w'(1);
    ready_sel    = 1'b0;
    release_mask = '0;
    for (int i = 0; i < num_stages_p; i++) begin
      if (idx_q == c_idx_w'(i)) begin
        ready_sel = stage_ready_i[i];
      end
      if (idx_nxt == c_idx_w'(i)) begin
        release_mask[i] = 1'b1;
      end
    end
  end

  // Sequencing state machine next-state logic; restart overrides everything.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    stage_reset_d = stage_reset_q;
    done_d        = done_q;
    error_d       = error_q;
    err_stage_d   = err_stage_q;

    case (state_q)
      s_hold: begin
        stage_reset_d = '1;
        if (cnt_q == c_hold_last) begin
          stage_reset_d[0] = 1'b0;
          cnt_d            = '0;
          state_d          = s_wait;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      s_wait: begin
        // Settle time: the stage's ready is deliberately not looked at here.
        if (cnt_q == c_wait_last) begin
          cnt_d   = '0;
          state_d = s_check;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      s_check: begin
        // A ready seen on the final timeout edge still counts as success.
        if (ready_sel) begin
          cnt_d = '0;
          if (idx_q == c_idx_last) begin
            done_d  = 1'b1;
            state_d = s_done;
          end else begin
            idx_d         = idx_nxt;
            stage_reset_d = stage_reset_q & ~release_mask;
            state_d       = s_wait;
          end
        end else if (cnt_q == c_timeout_last) begin
          error_d     = 1'b1;
          err_stage_d = idx_q;
          state_d     = s_error;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      s_done, s_error: begin
        // Terminal states: outputs hold until restart or reset.
      end
      default: begin
        // Illegal encoding: fall back to a full sequence from the start.
        stage_reset_d = '1;
        done_d        = 1'b0;
        error_d       = 1'b0;
        err_stage_d   = '0;
        idx_d         = '0;
        cnt_d         = '0;
        state_d       = s_hold;
      end
    endcase

    if (restart_i) begin
      stage_reset_d = '1;
      done_d        = 1'b0;
      error_d       = 1'b0;
      err_stage_d   = '0;
      idx_d         = '0;
      cnt_d         = '0;
      state_d       = s_hold;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q       <= s_hold;
      cnt_q         <= '0;
      idx_q         <= '0;
      stage_reset_q <= '1;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      err_stage_q   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      stage_reset_q <= stage_reset_d;
      done_q        <= done_d;
      error_q       <= error_d;
      err_stage_q   <= err_stage_d;
    end
  end

  assign stage_reset_o = stage_reset_q;
  assign done_o        = done_q;
  assign error_o       = error_q;
  assign err_stage_o   = err_stage_q;

endmodule
`default_nettype wire
